// File: rtl/reaction_game_ctrl.sv
// N-player reaction-timer controller: blink, random dark wait, timed run and judging,
// with per-player falling-edge press detection and saturating thermometer scores.

module rgc_player #(
  parameter int SCORE_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_n,
  input  logic               win,
  output logic               press,
  output logic [SCORE_W-1:0] score
);
  logic btn_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_q <= 1'b1;
      score <= '0;
    end else begin
      btn_q <= btn_n;
      // shifting a one in saturates naturally once the score is all-ones
      if (win) score <= {score[SCORE_W-2:0], 1'b1};
    end
  end

  assign press = btn_q & ~btn_n;
endmodule

module reaction_game_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int TIME_W       = 20,
  parameter int BLINK_MS     = 5000,
  parameter int BASE_WAIT_MS = 2000,
  parameter int RAND_W       = 12,
  parameter int CHEAT_MS     = 80,
  parameter int TIMEOUT_MS   = 9999,
  parameter int SCORE_W      = 5
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ms_tick,
  input  logic                           resume_n,
  input  logic [NUM_PLAYERS-1:0]         btn_n,
  output logic [2:0]                     disp_mode,
  output logic [TIME_W-1:0]              time_ms,
  output logic                           winner_valid,
  output logic [2:0]                     winner_id,
  output logic [NUM_PLAYERS-1:0]         cheat_mask,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);
  typedef enum logic [2:0] {
    S_RST, S_BLINK, S_WAIT, S_RUN, S_RESULT, S_CHEAT, S_TIE, S_TIMEOUT
  } state_t;

  localparam logic [2:0] M_DARK    = 3'd0;
  localparam logic [2:0] M_BLINK   = 3'd1;
  localparam logic [2:0] M_COUNT   = 3'd2;
  localparam logic [2:0] M_RESULT  = 3'd3;
  localparam logic [2:0] M_CHEAT   = 3'd4;
  localparam logic [2:0] M_TIE     = 3'd5;
  localparam logic [2:0] M_TIMEOUT = 3'd6;
  localparam logic [TIME_W-1:0] T_ONE = TIME_W'(1);

  state_t                  state;
  logic [15:0]             lfsr;
  logic [TIME_W-1:0]       ph_cnt, wait_ms;
  logic                    res_q, res_fall;
  logic [NUM_PLAYERS-1:0]  press, win_vec;
  logic                    any_press, one_press, early;
  logic [2:0]              press_id;

  genvar g;
  generate
    for (g = 0; g < NUM_PLAYERS; g++) begin : g_pl
      rgc_player #(.SCORE_W(SCORE_W)) u_pl (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn_n[g]),
        .win     (win_vec[g]),
        .press   (press[g]),
        .score   (scores[g*SCORE_W +: SCORE_W])
      );
    end
  endgenerate

  assign res_fall = res_q & ~resume_n;

  // Presses are judged against time_ms before any same-cycle tick increment.
  always_comb begin
    press_id = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (press[i]) press_id = 3'(i);
    any_press = |press;
    one_press = ($countones(press) == 1);
    early     = (time_ms < TIME_W'(CHEAT_MS));
    win_vec   = (state == S_RUN && one_press && !early) ? press : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_RST;
      lfsr         <= 16'hACE1;
      res_q        <= 1'b1;
      ph_cnt       <= '0;
      wait_ms      <= '0;
      disp_mode    <= M_BLINK;
      time_ms      <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      cheat_mask   <= '0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      res_q <= resume_n;
      case (state)
        S_RST: begin
          state     <= S_BLINK;
          disp_mode <= M_BLINK;
          ph_cnt    <= '0;
        end
        S_BLINK: if (ms_tick) begin
          if (ph_cnt == TIME_W'(BLINK_MS - 1)) begin
            state     <= S_WAIT;
            disp_mode <= M_DARK;
            ph_cnt    <= '0;
            wait_ms   <= TIME_W'(BASE_WAIT_MS) + TIME_W'(lfsr[RAND_W-1:0]);
          end else begin
            ph_cnt <= ph_cnt + T_ONE;
          end
        end
        S_WAIT: begin
          if (!(&btn_n)) begin
            state      <= S_CHEAT;
            disp_mode  <= M_CHEAT;
            cheat_mask <= ~btn_n;
          end else if (ms_tick) begin
            if (ph_cnt == wait_ms - T_ONE) begin
              state     <= S_RUN;
              disp_mode <= M_COUNT;
              time_ms   <= '0;
            end else begin
              ph_cnt <= ph_cnt + T_ONE;
            end
          end
        end
        S_RUN: begin
          if (any_press) begin
            if (early) begin
              state      <= S_CHEAT;
              disp_mode  <= M_CHEAT;
              cheat_mask <= press;
            end else if (one_press) begin
              state        <= S_RESULT;
              disp_mode    <= M_RESULT;
              winner_valid <= 1'b1;
              winner_id    <= press_id;
            end else begin
              state     <= S_TIE;
              disp_mode <= M_TIE;
            end
          end else if (ms_tick) begin
            time_ms <= time_ms + T_ONE;
            if (time_ms == TIME_W'(TIMEOUT_MS - 1)) begin
              state     <= S_TIMEOUT;
              disp_mode <= M_TIMEOUT;
            end
          end
        end
        default: if (res_fall) begin
          state        <= S_BLINK;
          disp_mode    <= M_BLINK;
          ph_cnt       <= '0;
          cheat_mask   <= '0;
          winner_valid <= 1'b0;
          time_ms      <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Randomized round-level bench for reaction_game_ctrl; outcomes and scores come from
// a round-outcome model driven by win counts and the timing rules of the game.

module tb_reaction_game_ctrl;
  localparam int NP = 3;
  localparam int TW = 20;
  localparam int SW = 3;
  localparam int BL = 10;
  localparam int CH = 3;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ms_tick = 1'b0;
  logic          resume_n = 1'b1;
  logic [NP-1:0] btn_n = '1;
  logic [2:0]    disp_mode, winner_id;
  logic [TW-1:0] time_ms;
  logic          winner_valid;
  logic [NP-1:0] cheat_mask;
  logic [NP*SW-1:0] scores;

  int n_tests = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int blink_t0 = 0;
  int wins [NP];

  reaction_game_ctrl #(
    .NUM_PLAYERS(NP), .TIME_W(TW), .BLINK_MS(BL), .BASE_WAIT_MS(5), .RAND_W(2),
    .CHEAT_MS(CH), .TIMEOUT_MS(TO), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ms_tick(ms_tick), .resume_n(resume_n), .btn_n(btn_n),
    .disp_mode(disp_mode), .time_ms(time_ms), .winner_valid(winner_valid),
    .winner_id(winner_id), .cheat_mask(cheat_mask), .scores(scores)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      ms_tick = 1'b1;
      @(negedge clk);
      ms_tick = 1'b0;
    end
  end

  always @(posedge clk) if (ms_tick) tick_cnt <= tick_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_scores();
    logic [31:0] v;
    int k;
    v = '0;
    for (int i = 0; i < NP; i++) begin
      k = (wins[i] > SW) ? SW : wins[i];
      v = v | (((32'd1 << k) - 32'd1) << (i * SW));
    end
    return v;
  endfunction

  task automatic predict(input logic [NP-1:0] m, input int t,
                         output logic [2:0] mode, output logic [2:0] wid);
    wid = '0;
    for (int i = 0; i < NP; i++) if (m[i]) wid = 3'(i);
    if (t < CH) mode = 3'd4;
    else if ($countones(m) == 1) mode = 3'd3;
    else mode = 3'd5;
  endtask

  task automatic wait_mode(input logic [2:0] m, input int budget, input string tag);
    int n;
    n = 0;
    while (disp_mode !== m && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, disp_mode, m);
  endtask

  task automatic blink_ignore();
    @(negedge clk); resume_n = 1'b0;
    @(posedge clk); #1;
    chk("res_ign_blink", disp_mode, 3'd1);
    @(negedge clk); resume_n = 1'b1;
  endtask

  task automatic reset_seq();
    @(negedge clk);
    reset_n = 1'b0; btn_n = '1; resume_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) wins[i] = 0;
    chk("rst_mode", disp_mode, 3'd1);
    chk("rst_time", time_ms, 0);
    chk("rst_wv", winner_valid, 0);
    chk("rst_wid", winner_id, 0);
    chk("rst_cm", cheat_mask, 0);
    chk("rst_scores", scores, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    blink_t0 = tick_cnt;
    chk("rst_to_blink", disp_mode, 3'd1);
    blink_ignore();
  endtask

  task automatic do_resume(input logic [2:0] m);
    repeat (3) @(posedge clk);
    #1;
    chk("hold", disp_mode, m);
    @(negedge clk); resume_n = 1'b0;
    @(posedge clk); #1;
    blink_t0 = tick_cnt;
    chk("res_mode", disp_mode, 3'd1);
    chk("res_cm", cheat_mask, 0);
    chk("res_wv", winner_valid, 0);
    chk("res_time", time_ms, 0);
    chk("res_scores", scores, exp_scores());
    @(negedge clk); resume_n = 1'b1;
    if ($urandom_range(0, 1) == 1) blink_ignore();
  endtask

  task automatic enter_run();
    int w0;
    wait_mode(3'd0, 200, "to_wait");
    chk("blink_len", tick_cnt - blink_t0, BL);
    w0 = tick_cnt;
    wait_mode(3'd2, 200, "to_run");
    chk("wait_len_ok", ((tick_cnt - w0) >= 5 && (tick_cnt - w0) <= 8) ? 1 : 0, 1);
    chk("run_t0", time_ms, 0);
  endtask

  task automatic press_round(input logic [NP-1:0] m, input int tp, input bit pulse);
    int t, n;
    logic [2:0] em, ew;
    enter_run();
    t = 0; n = 0;
    while (t < tp) begin
      @(negedge clk); resume_n = !(pulse && n == 0);
      @(posedge clk); if (ms_tick) t++;
      #1;
      if (pulse && n == 0) chk("res_ign_run", disp_mode, 3'd2);
      n++;
    end
    @(negedge clk); resume_n = 1'b1; btn_n = ~m;
    @(posedge clk); #1;
    predict(m, tp, em, ew);
    if (em == 3'd3) wins[ew]++;
    chk("outcome", disp_mode, em);
    if (em == 3'd3) begin
      chk("win_valid", winner_valid, 1);
      chk("win_id", winner_id, ew);
      chk("win_time", time_ms, tp);
    end else begin
      chk("no_win", winner_valid, 0);
    end
    chk("cheat_mask", cheat_mask, (em == 3'd4) ? m : '0);
    chk("scores", scores, exp_scores());
    @(negedge clk); btn_n = '1;
    do_resume(em);
  endtask

  task automatic wait_cheat_round(input logic [NP-1:0] m, input int d);
    wait_mode(3'd0, 200, "to_wait");
    chk("blink_len", tick_cnt - blink_t0, BL);
    repeat (d) @(posedge clk);
    @(negedge clk); btn_n = ~m;
    @(posedge clk); #1;
    chk("wcheat_mode", disp_mode, 3'd4);
    chk("wcheat_mask", cheat_mask, m);
    chk("wcheat_wv", winner_valid, 0);
    chk("wcheat_scores", scores, exp_scores());
    @(negedge clk); btn_n = '1;
    do_resume(3'd4);
  endtask

  task automatic timeout_round();
    int r0;
    enter_run();
    r0 = tick_cnt;
    wait_mode(3'd6, 300, "to_timeout");
    chk("run_len", tick_cnt - r0, TO);
    chk("to_wv", winner_valid, 0);
    chk("to_scores", scores, exp_scores());
    do_resume(3'd6);
  endtask

  task automatic reset_round();
    enter_run();
    repeat ($urandom_range(1, 20)) @(posedge clk);
    reset_seq();
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] tie_m [4];
    tie_m = '{3'b011, 3'b101, 3'b110, 3'b111};
    reset_seq();
    timeout_round();
    press_round(3'b010, 20, 1'b0);
    wait_cheat_round(3'b100, 3);
    press_round(3'b101, 12, 1'b0);
    press_round(3'b010, 2, 1'b0);
    press_round(3'b100, CH, 1'b0);
    press_round(3'b100, TO - 1, 1'b0);
    for (int r = 0; r < 4; r++)
      press_round(3'b001, int'($urandom_range(CH, TO - 1)), 1'b1);
    reset_round();
    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 5))
        0, 1: press_round(3'(1 << $urandom_range(0, NP - 1)),
                          int'($urandom_range(CH, TO - 1)), 1'($urandom_range(0, 1)));
        2: press_round(tie_m[$urandom_range(0, 3)], int'($urandom_range(CH, TO - 1)), 1'b0);
        3: press_round(3'($urandom_range(1, 7)), int'($urandom_range(0, CH - 1)), 1'b0);
        4: wait_cheat_round(3'($urandom_range(1, 7)), int'($urandom_range(0, 8)));
        default: timeout_round();
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reaction_game_ctrl.md
# reaction_game_ctrl

- Parametrised N-player reaction-timer controller; successor to the fixed two-player game FSM.
- Runs the blink, random-wait, timing and judging sequence on a 1 ms tick, and keeps thermometer scores per player.
- Reports cheats, ties and timeouts.
- Sits between the ms clock divider and button conditioning on one side, and the BCD/7-seg display path and LEDs on the other.

## Interface
Parameters:
- NUM_PLAYERS, 2: player count, 2..8.
- TIME_W, 20: width of ms counters and time_ms.
- BLINK_MS, 5000: blink phase length.
- BASE_WAIT_MS, 2000: fixed part of the dark wait.
- RAND_W, 12: LFSR bits added to the wait, ≤16.
- CHEAT_MS, 80: a press in RUN with time_ms < CHEAT_MS is a cheat.
- TIMEOUT_MS, 9999: RUN ends with no winner at this value.
- SCORE_W, 5: thermometer score width per player.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- ms_tick  in  1  one-clk pulse per ms.
- resume_n  in  1  active-low, already synchronised; the falling edge starts the next round.
- btn_n  in  NUM_PLAYERS  active-low player buttons, already synchronised; bit i is player i.
- disp_mode  out  3  display mode: 0 dark, 1 blink, 2 counting, 3 result, 4 cheat, 5 tie, 6 timeout.
- time_ms  out  TIME_W  RUN count, frozen in RESULT.
- winner_valid  out  1  high for the whole RESULT state.
- winner_id  out  3  index of the winning player.
- cheat_mask  out  NUM_PLAYERS  players flagged in CHEAT.
- scores  out  NUM_PLAYERS*SCORE_W  player i occupies [i*SCORE_W +: SCORE_W].

## Operation
States: RST, BLINK, WAIT, RUN, RESULT, CHEAT, TIE, TIMEOUT.

- **RST**: entered on reset. Goes to BLINK next clk.
- **BLINK**
  - Phase counter clears on entry; disp_mode = 1.
  - After BLINK_MS ticks, go to WAIT.
  - On that transition, latch wait_ms = BASE_WAIT_MS + lfsr[RAND_W-1:0].
- **WAIT**
  - disp_mode = 0.
  - If any btn_n bit is low (level) in any WAIT cycle: cheat_mask = inverted btn_n, go to CHEAT.
  - Otherwise, after wait_ms ticks, go to RUN.
- **RUN**
  - time_ms clears to 0 on entry and increments per tick; disp_mode = 2.
  - Press = registered falling edge of btn_n[i].
  - If the set of presses in a cycle is non-empty:
    - time_ms < CHEAT_MS: the pressers become cheat_mask, go to CHEAT.
    - Exactly one presser: winner_id = i, go to RESULT.
    - Two or more pressers: go to TIE.
  - If time_ms reaches TIMEOUT_MS first: go to TIMEOUT.
- **RESULT**: disp_mode = 3; time_ms holds the value at the press cycle. The winner's score updates as `s <= {s[SCORE_W-2:0],1'b1}`, saturating at all-ones, once, on entry.
- **CHEAT**: disp_mode = 4; no score change.
- **TIE**: disp_mode = 5; no score change.
- **TIMEOUT**: disp_mode = 6; no score change.
- **Resume**: a resume_n falling edge in RESULT, CHEAT, TIE or TIMEOUT goes to BLINK and clears cheat_mask, winner_valid and time_ms. It is ignored in BLINK, WAIT and RUN.
- **LFSR**
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every clk, independent of ms_tick.
  - Reset seed 16'hACE1; never reaches zero.
- **Reset values**
  - Held by reset: state RST, all scores 0, disp_mode 1, time_ms 0, winner_valid 0, winner_id 0, cheat_mask 0, LFSR seed.
  - Reset mid-round aborts immediately and clears scores.
  - Resume never clears scores.

## Timing
- All outputs are registered.
- Button and resume edges: registered falling edge detected in cycle t, state change visible in cycle t+1.
- winner_valid, scores, cheat_mask and disp_mode update in the same cycle as the state change.
- Phase counters advance only on ms_tick cycles; state length = N ticks ±1 clk.
- A tick and a press in the same cycle: the press is judged with the pre-increment time_ms.
- A tick and reset_n low in the same cycle: reset wins.
- A score already all-ones stays all-ones.
- winner_id is meaningful only while winner_valid = 1.

## Test plan
Bench parameters: NUM_PLAYERS=3, BLINK_MS=10, BASE_WAIT_MS=5, RAND_W=2, CHEAT_MS=3, TIMEOUT_MS=50, SCORE_W=3; ms_tick every 4 clk.

1. Reset, no presses:
   - disp_mode goes 1 for 10 ticks, then 0 for 5..8 ticks, then 2.
   - After 50 ticks in RUN, disp_mode = 6 and all scores stay 0.
2. Player 1 presses at RUN time_ms=20:
   - Next clk: disp_mode = 3, winner_valid = 1, winner_id = 1, time_ms = 20.
   - scores = {000,001,000}.
3. Player 2 holds the button low during WAIT:
   - Next clk: disp_mode = 4, cheat_mask = 3'b100, scores unchanged.
   - A resume_n falling edge returns to BLINK with cheat_mask = 0.
4. Players 0 and 2 press in the same clk at time_ms=12: disp_mode = 5, no score change. Player 1 pressing at time_ms=2: disp_mode = 4, cheat_mask = 3'b010.
5. Player 0 wins 4 rounds: its score goes 001, 011, 111, 111 (saturates). resume_n pulsed during RUN is ignored.
6. reset_n asserted mid-RUN with scores non-zero: next clk all outputs are at their reset values and scores are 0. resume_n pulsed during BLINK is ignored.
